motion_step_driver: RTL and testbench

Downstream consumer of the processor selector's muxed outputs (num_steps_x/y, servo_pos). On a one-cycle trigger it latches a signed relative move and servo target. If the servo target changes, it sets the servo and waits for a settle interval. It then emits paced step/dir pulses on both stepper axes concurrently. When the move finishes it returns a one-cycle stepper_done pulse, which feeds the selector's stepper_done_in.

---
 rtl/motion_step_driver.sv | 189 ++++++++++++++++++
 tb/tb_motion_step_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/motion_step_driver.sv
// motion_step_driver: latches a signed relative XY move plus a pen (servo)
// target, optionally waits for the servo to settle, then paces step/dir
// pulses on both axes concurrently and signals completion with a one-cycle
// stepper_done_out pulse.
// Optional build macro: MOTION_POSITION_TRACK_EN adds signed position
// counters pos_x_out / pos_y_out (POS_BITS wide) updated on every step.
`timescale 1ns/1ps

package Servo_p;
  typedef enum logic [0:0] {
    SERVO_POS_DOWN = 1'b0,
    SERVO_POS_UP   = 1'b1
  } ServoPosition_t;
endpackage

module motion_step_driver #(
  parameter int STEPPER_X_BITS    = 16,
  parameter int STEPPER_Y_BITS    = 16,
  parameter int STEP_PERIOD_CLKS  = 4,
  parameter int SERVO_SETTLE_CLKS = 8
`ifdef MOTION_POSITION_TRACK_EN
  , parameter int POS_BITS        = 24
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger_in,
  input  logic [STEPPER_X_BITS-1:0]   num_steps_x_in,
  input  logic [STEPPER_Y_BITS-1:0]   num_steps_y_in,
  input  Servo_p::ServoPosition_t     servo_pos_in,
  output Servo_p::ServoPosition_t     servo_pos_out,
  output logic                        step_x_out,
  output logic                        dir_x_out,
  output logic                        step_y_out,
  output logic                        dir_y_out,
  output logic                        busy_out,
  output logic                        stepper_done_out
`ifdef MOTION_POSITION_TRACK_EN
  , output logic signed [POS_BITS-1:0] pos_x_out
  , output logic signed [POS_BITS-1:0] pos_y_out
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Tick counter spans 0..P-1; settle counter spans 0..S-1 (width kept >= 1).
  localparam int TICK_W   = (STEP_PERIOD_CLKS > 1) ? $clog2(STEP_PERIOD_CLKS) : 1;
  localparam int SETTLE_W = $clog2(SERVO_SETTLE_CLKS + 1);

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(STEP_PERIOD_CLKS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SERVO_SETTLE_CLKS - 1);

  logic [1:0]                  state_q, state_d;
  logic [STEPPER_X_BITS-1:0]   rem_x_q, rem_x_d;
  logic [STEPPER_Y_BITS-1:0]   rem_y_q, rem_y_d;
  logic                        dir_x_q, dir_x_d;
  logic                        dir_y_q, dir_y_d;
  logic [TICK_W-1:0]           tick_q, tick_d;
  logic [SETTLE_W-1:0]         settle_q, settle_d;
  Servo_p::ServoPosition_t     servo_q, servo_d;

  // Magnitudes of the requested move; the most negative value maps to
  // 2^(B-1), which still fits in the unsigned B-bit counter.
  logic [STEPPER_X_BITS-1:0]   abs_x;
  logic [STEPPER_Y_BITS-1:0]   abs_y;
  logic                        tick_zero;

  assign abs_x = num_steps_x_in[STEPPER_X_BITS-1]
               ? (~num_steps_x_in + STEPPER_X_BITS'(1)) : num_steps_x_in;
  assign abs_y = num_steps_y_in[STEPPER_Y_BITS-1]
               ? (~num_steps_y_in + STEPPER_Y_BITS'(1)) : num_steps_y_in;
  assign tick_zero = (tick_q == '0);

  // Next-state logic for the move sequencer.
  always_comb begin
    state_d  = state_q;
    rem_x_d  = rem_x_q;
    rem_y_d  = rem_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    tick_d   = tick_q;
    settle_d = settle_q;
    servo_d  = servo_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_in) begin
          rem_x_d = abs_x;
          rem_y_d = abs_y;
          dir_x_d = num_steps_x_in[STEPPER_X_BITS-1];
          dir_y_d = num_steps_y_in[STEPPER_Y_BITS-1];
          if (servo_pos_in != servo_q) begin
            servo_d  = servo_pos_in;
            settle_d = SETTLE_INIT;
            state_d  = ST_SETTLE;
          end else begin
            tick_d  = TICK_W'(1);
            state_d = ST_STEP;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          tick_d  = TICK_W'(1);
          state_d = ST_STEP;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_STEP: begin
        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        if (tick_zero) begin
          if (rem_x_q != '0) rem_x_d = rem_x_q - STEPPER_X_BITS'(1);
          if (rem_y_q != '0) rem_y_d = rem_y_q - STEPPER_Y_BITS'(1);
          if ((rem_x_q == '0) && (rem_y_q == '0)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any move in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_x_q  <= '0;
      rem_y_q  <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      tick_q   <= '0;
      settle_q <= '0;
      servo_q  <= Servo_p::SERVO_POS_UP;
    end else begin
      state_q  <= state_d;
      rem_x_q  <= rem_x_d;
      rem_y_q  <= rem_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      servo_q  <= servo_d;
    end
  end

  // Moore outputs decoded from registered state only.
  assign step_x_out       = (state_q == ST_STEP) && tick_zero && (rem_x_q != '0);
  assign step_y_out       = (state_q == ST_STEP) && tick_zero && (rem_y_q != '0);
  assign dir_x_out        = dir_x_q;
  assign dir_y_out        = dir_y_q;
  assign busy_out         = (state_q != ST_IDLE);
  assign stepper_done_out = (state_q == ST_DONE);
  assign servo_pos_out    = servo_q;

`ifdef MOTION_POSITION_TRACK_EN
  logic signed [POS_BITS-1:0] pos_x_q, pos_x_d;
  logic signed [POS_BITS-1:0] pos_y_q, pos_y_d;

  // Position follows each issued step; wraps modulo 2^POS_BITS.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (step_x_out) pos_x_d = dir_x_q ? (pos_x_q - POS_BITS'(1)) : (pos_x_q + POS_BITS'(1));
    if (step_y_out) pos_y_d = dir_y_q ? (pos_y_q - POS_BITS'(1)) : (pos_y_q + POS_BITS'(1));
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign pos_x_out = pos_x_q;
  assign pos_y_out = pos_y_q;
`endif

endmodule

// File: tb/tb_motion_step_driver.sv
// Testbench for motion_step_driver: expected step/done events are queued by
// the stimulus and popped by a monitor whenever a DUT pulse appears.
// A second instance with 4-bit step counts covers the most-negative input.
`timescale 1ns/1ps

module tb_motion_step_driver;
  import Servo_p::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (16-bit counts)
  logic           trig0 = 1'b0;
  logic [15:0]    nx0 = '0, ny0 = '0;
  ServoPosition_t srv_in0 = SERVO_POS_UP;
  ServoPosition_t srv_out0;
  logic sx0, dx0, sy0, dy0, busy0, done0;

  // Narrow instance (4-bit counts)
  logic           trig1 = 1'b0;
  logic [3:0]     nx1 = '0, ny1 = '0;
  ServoPosition_t srv_in1 = SERVO_POS_UP;
  ServoPosition_t srv_out1;
  logic sx1, dx1, sy1, dy1, busy1, done1;

`ifdef MOTION_POSITION_TRACK_EN
  logic signed [23:0] posx0, posy0, posx1, posy1;
`endif

  motion_step_driver #(.STEPPER_X_BITS(16), .STEPPER_Y_BITS(16),
                       .STEP_PERIOD_CLKS(4), .SERVO_SETTLE_CLKS(8)) dut0 (
    .clk(clk), .reset(reset), .trigger_in(trig0),
    .num_steps_x_in(nx0), .num_steps_y_in(ny0),
    .servo_pos_in(srv_in0), .servo_pos_out(srv_out0),
    .step_x_out(sx0), .dir_x_out(dx0), .step_y_out(sy0), .dir_y_out(dy0),
    .busy_out(busy0), .stepper_done_out(done0)
`ifdef MOTION_POSITION_TRACK_EN
    , .pos_x_out(posx0), .pos_y_out(posy0)
`endif
  );

  motion_step_driver #(.STEPPER_X_BITS(4), .STEPPER_Y_BITS(4),
                       .STEP_PERIOD_CLKS(4), .SERVO_SETTLE_CLKS(8)) dut1 (
    .clk(clk), .reset(reset), .trigger_in(trig1),
    .num_steps_x_in(nx1), .num_steps_y_in(ny1),
    .servo_pos_in(srv_in1), .servo_pos_out(srv_out1),
    .step_x_out(sx1), .dir_x_out(dx1), .step_y_out(sy1), .dir_y_out(dy1),
    .busy_out(busy1), .stepper_done_out(done1)
`ifdef MOTION_POSITION_TRACK_EN
    , .pos_x_out(posx1), .pos_y_out(posy1)
`endif
  );

  typedef struct {
    int   cyc;
    logic sx;
    logic sy;
    logic dn;
    logic dx;
    logic dy;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic evt_t mk(input int c, input logic sx, input logic sy,
                              input logic dn, input logic dx, input logic dy);
    evt_t e;
    e.cyc = c; e.sx = sx; e.sy = sy; e.dn = dn; e.dx = dx; e.dy = dy;
    return e;
  endfunction

  task automatic chk(input string name, input logic ok, input int got, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end else begin
      $display("[TB] ok   %s = %0d (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go0(input logic [15:0] x, input logic [15:0] y,
                     input ServoPosition_t s, output int t0);
    @(negedge clk);
    nx0 = x; ny0 = y; srv_in0 = s; trig0 = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    trig0 = 1'b0;
  endtask

  initial begin
    int t0, t1;
    evt_t e;
    fork
      // Monitor: every pulse from either instance must match the queue head.
      begin
        forever begin
          @(negedge clk);
          if (sx0 || sy0 || done0) begin
            if (q0.size() == 0) begin
              chk("dut0 unexpected pulse", 1'b0, {sx0, sy0, done0}, 0);
            end else begin
              e = q0.pop_front();
              chk($sformatf("dut0 evt sx/sy/dn/dx/dy=%b%b%b%b%b @%0d",
                            sx0, sy0, done0, dx0, dy0, cyc),
                  (cyc == e.cyc) && (sx0 == e.sx) && (sy0 == e.sy) &&
                  (done0 == e.dn) && (e.dn || ((dx0 == e.dx) && (dy0 == e.dy))),
                  cyc, e.cyc);
            end
          end
          if (sx1 || sy1 || done1) begin
            if (q1.size() == 0) begin
              chk("dut1 unexpected pulse", 1'b0, {sx1, sy1, done1}, 0);
            end else begin
              e = q1.pop_front();
              chk($sformatf("dut1 evt sx/sy/dn/dx/dy=%b%b%b%b%b @%0d",
                            sx1, sy1, done1, dx1, dy1, cyc),
                  (cyc == e.cyc) && (sx1 == e.sx) && (sy1 == e.sy) &&
                  (done1 == e.dn) && (e.dn || ((dx1 == e.dx) && (dy1 == e.dy))),
                  cyc, e.cyc);
            end
          end
        end
      end
      // Watchdog
      begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, got cycle %0d, required < 5000", cyc);
        $fatal(1, "watchdog");
      end
      // Stimulus
      begin
        // 1. Reset with trigger held high
        reset = 1'b1; trig0 = 1'b1; trig1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", busy0 == 1'b0, busy0, 0);
        chk("reset done", done0 == 1'b0, done0, 0);
        chk("reset servo UP", srv_out0 == SERVO_POS_UP, srv_out0, SERVO_POS_UP);
        chk("reset steps/dirs", {sx0, sy0, dx0, dy0} == 4'b0, {sx0, sy0, dx0, dy0}, 0);
        reset = 1'b0; trig0 = 1'b0; trig1 = 1'b0;
        repeat (2) @(negedge clk);

        // 2. (3,-2), servo unchanged
        go0(16'd3, 16'hFFFE, SERVO_POS_UP, t0);
        q0.push_back(mk(t0 + 3,  1, 1, 0, 0, 1));
        q0.push_back(mk(t0 + 7,  1, 1, 0, 0, 1));
        q0.push_back(mk(t0 + 11, 1, 0, 0, 0, 1));
        q0.push_back(mk(t0 + 16, 0, 0, 1, 0, 1));
        chk("t2 busy at cycle 1", busy0 == 1'b1, busy0, 1);
        wait_until(t0 + 16);
        chk("t2 busy at cycle 16", busy0 == 1'b1, busy0, 1);
        @(negedge clk);
        chk("t2 idle at cycle 17", busy0 == 1'b0, busy0, 0);
        chk("t2 all events seen", q0.size() == 0, q0.size(), 0);

        // 3. (1,1), servo UP -> DOWN
        go0(16'd1, 16'd1, SERVO_POS_DOWN, t0);
        chk("t3 servo DOWN", srv_out0 == SERVO_POS_DOWN, srv_out0, SERVO_POS_DOWN);
        q0.push_back(mk(t0 + 11, 1, 1, 0, 0, 0));
        q0.push_back(mk(t0 + 16, 0, 0, 1, 0, 0));
        wait_until(t0 + 18);
        chk("t3 all events seen", q0.size() == 0, q0.size(), 0);

        // 4. (0,0) with re-trigger while busy
        go0(16'd0, 16'd0, SERVO_POS_DOWN, t0);
        q0.push_back(mk(t0 + 4, 0, 0, 1, 0, 0));
        nx0 = 16'd5; ny0 = 16'd5; trig0 = 1'b1;
        @(negedge clk);
        trig0 = 1'b0;
        wait_until(t0 + 30);
        chk("t4 all events seen", q0.size() == 0, q0.size(), 0);
        chk("t4 idle after ignored trigger", busy0 == 1'b0, busy0, 0);

        // 5. Narrow instance, (-8,0)
        @(negedge clk);
        nx1 = 4'h8; ny1 = 4'h0; srv_in1 = SERVO_POS_UP; trig1 = 1'b1;
        t1 = cyc + 1;
        @(negedge clk);
        trig1 = 1'b0;
        for (int k = 1; k <= 8; k++) q1.push_back(mk(t1 + 4 * k - 1, 1, 0, 0, 1, 0));
        q1.push_back(mk(t1 + 36, 0, 0, 1, 1, 0));
        wait_until(t1 + 38);
        chk("t5 all events seen", q1.size() == 0, q1.size(), 0);
        chk("t5 dir_x negative", dx1 == 1'b1, dx1, 1);
`ifdef MOTION_POSITION_TRACK_EN
        chk("t5 pos_x", posx1 == -24'sd8, posx1, -8);
        chk("t5 pos_y", posy1 == 24'sd0, posy1, 0);
`endif

        // 6. (10,10) aborted by reset at cycle 9
        go0(16'd10, 16'd10, SERVO_POS_DOWN, t0);
        q0.push_back(mk(t0 + 3, 1, 1, 0, 0, 0));
        q0.push_back(mk(t0 + 7, 1, 1, 0, 0, 0));
        wait_until(t0 + 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6 busy after reset", busy0 == 1'b0, busy0, 0);
        chk("t6 servo UP after reset", srv_out0 == SERVO_POS_UP, srv_out0, SERVO_POS_UP);
        wait_until(t0 + 24);
        chk("t6 no pulses after abort", q0.size() == 0, q0.size(), 0);

        go0(16'd2, 16'd0, SERVO_POS_UP, t0);
        q0.push_back(mk(t0 + 3,  1, 0, 0, 0, 0));
        q0.push_back(mk(t0 + 7,  1, 0, 0, 0, 0));
        q0.push_back(mk(t0 + 12, 0, 0, 1, 0, 0));
        wait_until(t0 + 14);
        chk("t6 post-reset move complete", q0.size() == 0, q0.size(), 0);
        chk("t6 idle at end", busy0 == 1'b0, busy0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join_any
  end

endmodule
